// File: rtl/pwm_cfg_pkg.sv
// Shared PWM configuration: channel count, duty range, reset duties, commit FSM states.
package pwm_cfg_pkg;

    localparam int unsigned NCH      = 8;
    localparam int unsigned DUTY_MAX = 100;
    localparam int unsigned DW       = 8;
    localparam int unsigned CHW      = 3;

    // Reset duty values, channel 7 in the MSBs down to channel 0 in the LSBs
    localparam logic [NCH*DW-1:0] RST_DUTY = {8'd80, 8'd10, 8'd75, 8'd40,
                                              8'd20, 8'd50, 8'd25, 8'd15};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } commit_state_e;

endpackage

// File: rtl/duty_clamp.sv
// Saturates an incoming duty value at DUTY_MAX and flags when it had to.
module duty_clamp #(
    parameter int unsigned DW       = 8,
    parameter int unsigned DUTY_MAX = 100
) (
    input  logic [DW-1:0] duty_in,
    output logic [DW-1:0] duty_out_c,
    output logic          clamp_c
);

    localparam logic [DW-1:0] MAX_V = DW'(DUTY_MAX);

    // Compare against the terminal count and saturate
    always_comb begin
        clamp_c    = (duty_in > MAX_V);
        duty_out_c = clamp_c ? MAX_V : duty_in;
    end

endmodule

// File: rtl/duty_cfg_bank.sv
// Shadow/active duty register bank; host edits go to shadow, commits land on frame boundaries.
module duty_cfg_bank #(
    parameter int unsigned             NCH      = pwm_cfg_pkg::NCH,
    parameter int unsigned             DUTY_MAX = pwm_cfg_pkg::DUTY_MAX,
    parameter int unsigned             DW       = pwm_cfg_pkg::DW,
    parameter logic [NCH*DW-1:0]       RST_DUTY = pwm_cfg_pkg::RST_DUTY
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [2:0]          wr_ch,
    input  logic [DW-1:0]       wr_duty,
    input  logic                commit_req,
    input  logic                frame_sync,
    output logic [NCH*DW-1:0]   duty_act,
    output logic                commit_pending,
    output logic                commit_done,
    output logic [7:0]          commit_cnt,
    output logic                err_range,
    input  logic                err_clr
);

    import pwm_cfg_pkg::*;

    localparam int unsigned CW = 3;

    commit_state_e       state_q, state_d;
    logic                pending_q, pending_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [NCH*DW-1:0]   shadow_q, shadow_d;
    logic [NCH*DW-1:0]   act_q, act_d;

    logic [DW-1:0]       clamp_duty;
    logic                clamp_hit;
    logic                wr_fire;

    duty_clamp #(
        .DW       (DW),
        .DUTY_MAX (DUTY_MAX)
    ) u_clamp (
        .duty_in    (wr_duty),
        .duty_out_c (clamp_duty),
        .clamp_c    (clamp_hit)
    );

    // Next-state: shadow writes, sticky range error, commit FSM and active-bank transfer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        act_d    = act_q;
        done_d   = 1'b0;
        wr_fire  = wr_valid & ready_q;

        for (int unsigned i = 0; i < NCH; i++) begin
            if (wr_fire && (wr_ch == CW'(i))) begin
                shadow_d[i*DW +: DW] = clamp_duty;
            end
        end

        if (wr_fire && clamp_hit) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // frame_sync in this state never transfers; it only arms
                if (commit_req) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_sync) begin
                    state_d = ST_IDLE;
                    act_d   = shadow_q;
                    cnt_d   = cnt_q + 8'd1;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pending_d = (state_d == ST_ARMED);
        ready_d   = (state_d == ST_IDLE);
    end

    // State and output registers; both banks reload their reset duties asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            shadow_q  <= RST_DUTY;
            act_q     <= RST_DUTY;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            shadow_q  <= shadow_d;
            act_q     <= act_d;
        end
    end

    assign wr_ready       = ready_q;
    assign commit_pending = pending_q;
    assign commit_done    = done_q;
    assign commit_cnt     = cnt_q;
    assign err_range      = err_q;
    assign duty_act       = act_q;

endmodule

// File: tb/tb_duty_cfg_bank.sv
// Self-checking bench for duty_cfg_bank: directed table, corner sequences, random vs reference model.
module tb_duty_cfg_bank;

    localparam int unsigned NCH  = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned DMAX = 100;
    localparam logic [63:0] RST_V = {8'd80, 8'd10, 8'd75, 8'd40, 8'd20, 8'd50, 8'd25, 8'd15};

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_ch;
    logic [7:0]  wr_duty;
    logic        commit_req;
    logic        frame_sync;
    logic [63:0] duty_act;
    logic        commit_pending;
    logic        commit_done;
    logic [7:0]  commit_cnt;
    logic        err_range;
    logic        err_clr;

    duty_cfg_bank dut (
        .clk            (clk),
        .reset          (reset),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_ch          (wr_ch),
        .wr_duty        (wr_duty),
        .commit_req     (commit_req),
        .frame_sync     (frame_sync),
        .duty_act       (duty_act),
        .commit_pending (commit_pending),
        .commit_done    (commit_done),
        .commit_cnt     (commit_cnt),
        .err_range      (err_range),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: plain arrays and flags
    int rst_tab [8] = '{15, 25, 50, 20, 40, 75, 10, 80};
    int m_sh  [8];
    int m_act [8];
    bit m_pend, m_done, m_err;
    int m_cnt;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    endtask

    function automatic logic [63:0] m_pack();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(m_act[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_sh[i]  = rst_tab[i];
            m_act[i] = rst_tab[i];
        end
        m_pend = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic idle_in();
        wr_valid   = 1'b0;
        wr_ch      = 3'd0;
        wr_duty    = 8'd0;
        commit_req = 1'b0;
        frame_sync = 1'b0;
        err_clr    = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT
    task automatic step();
        bit fire, copy, clampv;
        int v;
        fire   = wr_valid && !m_pend;
        copy   = m_pend && frame_sync;
        clampv = fire && (int'(wr_duty) > int'(DMAX));
        if (fire) begin
            v = (int'(wr_duty) > int'(DMAX)) ? int'(DMAX) : int'(wr_duty);
            m_sh[int'(wr_ch)] = v;
        end
        if (clampv) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        if (copy) for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
        m_done = copy;
        if (copy) m_cnt = (m_cnt + 1) % 256;
        m_pend = m_pend ? !frame_sync : commit_req;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".duty_act"}, duty_act, m_pack());
        chk({tag, ".pending"},  64'(commit_pending), 64'(m_pend));
        chk({tag, ".ready"},    64'(wr_ready), 64'(!m_pend));
        chk({tag, ".done"},     64'(commit_done), 64'(m_done));
        chk({tag, ".cnt"},      64'(commit_cnt), 64'(m_cnt));
        chk({tag, ".err"},      64'(err_range), 64'(m_err));
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit       wv;
        bit [2:0] ch;
        bit [7:0] duty;
        bit       cr;
        bit       fs;
        bit       ec;
        bit       e_pend;
        bit       e_done;
        bit       e_err;
        bit [7:0] e_cnt;
        bit [2:0] c_ch;
        bit [7:0] e_act;
    } vec_t;

    vec_t vt [18];
    int   done_seen;

    initial begin
        // wv ch duty cr fs ec | pend done err cnt | chk_ch exp_act
        vt[0]  = '{1, 2,  33, 0, 0, 0, 0, 0, 0, 0, 2,  50};
        vt[1]  = '{0, 0,   0, 1, 0, 0, 1, 0, 0, 0, 2,  50};
        vt[2]  = '{0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 2,  50};
        vt[3]  = '{0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 2,  50};
        vt[4]  = '{0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 2,  50};
        vt[5]  = '{0, 0,   0, 0, 0, 0, 1, 0, 0, 0, 2,  50};
        vt[6]  = '{0, 0,   0, 0, 1, 0, 0, 1, 0, 1, 2,  33};
        vt[7]  = '{0, 0,   0, 0, 0, 0, 0, 0, 0, 1, 2,  33};
        vt[8]  = '{1, 5, 150, 0, 0, 0, 0, 0, 1, 1, 5,  75};
        vt[9]  = '{1, 5, 200, 0, 0, 1, 0, 0, 1, 1, 5,  75};
        vt[10] = '{0, 0,   0, 0, 0, 1, 0, 0, 0, 1, 5,  75};
        vt[11] = '{0, 0,   0, 1, 1, 0, 1, 0, 0, 1, 5,  75};
        vt[12] = '{1, 5,   7, 0, 0, 0, 1, 0, 0, 1, 5,  75};
        vt[13] = '{0, 0,   0, 0, 1, 0, 0, 1, 0, 2, 5, 100};
        vt[14] = '{0, 0,   0, 0, 0, 0, 0, 0, 0, 2, 5, 100};
        vt[15] = '{0, 0,   0, 0, 1, 0, 0, 0, 0, 2, 5, 100};
        vt[16] = '{1, 0,  60, 1, 0, 0, 1, 0, 0, 2, 0,  15};
        vt[17] = '{0, 0,   0, 0, 1, 0, 0, 1, 0, 3, 0,  60};

        // Reset values appear without a clock edge
        idle_in();
        reset = 1'b1;
        #1;
        chk("async_rst.duty_act", duty_act, RST_V);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("rst.duty_act", duty_act, RST_V);
        chk("rst.cnt",      64'(commit_cnt), 64'd0);
        chk("rst.ready",    64'(wr_ready), 64'd1);
        chk("rst.pending",  64'(commit_pending), 64'd0);
        chk("rst.done",     64'(commit_done), 64'd0);
        chk("rst.err",      64'(err_range), 64'd0);

        // Directed table
        for (int k = 0; k < 18; k++) begin
            wr_valid   = vt[k].wv;
            wr_ch      = vt[k].ch;
            wr_duty    = vt[k].duty;
            commit_req = vt[k].cr;
            frame_sync = vt[k].fs;
            err_clr    = vt[k].ec;
            step();
            chk($sformatf("vec%0d.pending", k), 64'(commit_pending), 64'(vt[k].e_pend));
            chk($sformatf("vec%0d.ready", k),   64'(wr_ready), 64'(!vt[k].e_pend));
            chk($sformatf("vec%0d.done", k),    64'(commit_done), 64'(vt[k].e_done));
            chk($sformatf("vec%0d.err", k),     64'(err_range), 64'(vt[k].e_err));
            chk($sformatf("vec%0d.cnt", k),     64'(commit_cnt), 64'(vt[k].e_cnt));
            chk($sformatf("vec%0d.act", k),     64'(duty_act[int'(vt[k].c_ch)*8 +: 8]), 64'(vt[k].e_act));
        end
        idle_in();

        // Reset while armed drops the pending commit and shadow edit
        wr_valid = 1'b1; wr_ch = 3'd0; wr_duty = 8'd90;
        step();
        idle_in();
        commit_req = 1'b1;
        step();
        commit_req = 1'b0;
        chk("midrst.armed", 64'(commit_pending), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst.act0",    64'(duty_act[7:0]), 64'd15);
        chk("midrst.pending", 64'(commit_pending), 64'd0);
        chk("midrst.ready",   64'(wr_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk_all("midrst_fs");
        chk("midrst.act0_after", 64'(duty_act[7:0]), 64'd15);

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            wr_valid   = ($urandom % 2) == 0;
            wr_ch      = 3'($urandom % 8);
            wr_duty    = (($urandom % 4) == 0) ? 8'($urandom % 256) : 8'($urandom % (DMAX + 1));
            commit_req = ($urandom % 4) == 0;
            frame_sync = ($urandom % 6) == 0;
            err_clr    = ($urandom % 8) == 0;
            step();
            chk_all($sformatf("rnd%0d", c));
        end
        idle_in();

        // 256 commits wrap the counter back to zero
        do_reset();
        done_seen = 0;
        for (int k = 0; k < 256; k++) begin
            commit_req = 1'b1;
            step();
            commit_req = 1'b0;
            if (commit_done) done_seen++;
            frame_sync = 1'b1;
            step();
            frame_sync = 1'b0;
            if (commit_done) done_seen++;
            if (k == 254) chk("wrap.cnt255", 64'(commit_cnt), 64'd255);
        end
        step();
        if (commit_done) done_seen++;
        chk("wrap.cnt0",  64'(commit_cnt), 64'd0);
        chk("wrap.dones", 64'(done_seen), 64'd256);
        chk_all("wrap_end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/duty_cfg_bank.md
DUTY_CFG_BANK -- requirements
Module: duty_cfg_bank

Interface
REQ-001 Parameter NCH, default 8: number of PWM channels.
REQ-002 Parameter DUTY_MAX, default 100: largest legal duty value, equal to the PWM counter terminal count.
REQ-003 Parameter DW, default 8: width of one duty value.
REQ-004 Parameter RST_DUTY, default {80,10,75,40,20,50,25,15} (channel 7..0): per-channel duty value loaded at reset.
REQ-005 clk  in  1  single clock for the block; all state SHALL update on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 wr_valid  in  1  host write request.
REQ-008 wr_ready  out  1  the block can accept a write.
REQ-009 wr_ch  in  3  target channel of the write.
REQ-010 wr_duty  in  DW  duty value to write.
REQ-011 commit_req  in  1  single-cycle pulse that requests shadow-to-active transfer.
REQ-012 frame_sync  in  1  single-cycle pulse from the PWM generator when its latch fires (frame boundary).
REQ-013 duty_act  out  NCH*DW  active duty values, flattened, channel 0 in the LSBs; the PWM generator consumes this bus.
REQ-014 commit_pending  out  1  a commit is armed and waiting for frame_sync.
REQ-015 commit_done  out  1  one-cycle pulse in the cycle after the active bank updates.
REQ-016 commit_cnt  out  8  number of completed commits, modulo 256.
REQ-017 err_range  out  1  sticky flag: a write was clamped.
REQ-018 err_clr  in  1  clears err_range.

Function
REQ-019 A write handshake SHALL occur in any cycle where wr_valid and wr_ready are both 1; the block SHALL then store wr_duty into shadow[wr_ch] at that clock edge.
REQ-020 If wr_duty > DUTY_MAX, the block SHALL store DUTY_MAX and set err_range on the same edge.
REQ-021 wr_ready SHALL equal NOT commit_pending, so the shadow bank is frozen while a commit is armed.
REQ-022 A commit_req arriving while idle SHALL set commit_pending on the next edge; a commit_req arriving while commit_pending is already 1 SHALL be ignored.
REQ-023 A write handshake and a commit_req in the same cycle SHALL both take effect, and the written value SHALL be part of the commit.
REQ-024 On a frame_sync with commit_pending=1, the block SHALL copy all shadow entries to the active bank in one edge, clear commit_pending, and increment commit_cnt (wrapping 255->0).
REQ-025 commit_done SHALL pulse high for exactly the cycle after the copy edge, which is the first cycle in which duty_act shows the new values.
REQ-026 frame_sync together with a commit_req that finds commit_pending=0 SHALL only arm the commit; the transfer SHALL occur on the next frame_sync, so the transfer never happens in the same cycle as the arming.
REQ-027 frame_sync with commit_pending=0 SHALL have no effect.
REQ-028 duty_act SHALL change only at commit edges and reset, so it never changes mid-frame.
REQ-029 The state machine SHALL have two states, IDLE (commit_pending=0) and ARMED (commit_pending=1):
- IDLE->ARMED on commit_req;
- ARMED->IDLE on frame_sync.
REQ-030 err_clr SHALL clear err_range; if a clamp occurs in the same cycle, the set SHALL win.

Reset
REQ-031 On reset, both the shadow and the active banks SHALL load RST_DUTY immediately, without waiting for a clock edge.
REQ-032 The outputs SHALL take these reset values: commit_pending=0, wr_ready=1, commit_done=0, commit_cnt=0, err_range=0.
REQ-033 Reset asserted while the block is ARMED SHALL discard the pending commit and any shadow edits.

Structure
REQ-034 NCH, DUTY_MAX, DW, the RST_DUTY default and the state enumeration SHALL live in a shared package pwm_cfg_pkg, which the PWM generator also uses.
REQ-035 A single sub-module, duty_clamp, SHALL perform the saturation against DUTY_MAX and generate the clamp flag.

Verification
REQ-036 Reset release check: after reset release, duty_act must equal {80,10,75,40,20,50,25,15}, commit_cnt must be 0 and wr_ready must be 1.
REQ-037 Basic commit: write ch2=33, then commit_req, then frame_sync 5 cycles later -> duty_act[ch2]=33 exactly one cycle after frame_sync, commit_done pulses once, commit_cnt=1.
REQ-038 Clamp: write ch5=150 -> shadow[5] is 100 and err_range=1; assert err_clr and a second clamping write in the same cycle -> err_range stays 1; a later err_clr alone -> err_range=0.
REQ-039 Simultaneous events: commit_req and frame_sync in the same cycle -> no transfer; the next frame_sync transfers; a write attempted while ARMED sees wr_ready=0 and is not stored.
REQ-040 Mid-operation reset: write ch0=60, commit_req, then reset before frame_sync -> duty_act[ch0]=15 and commit_pending=0.
REQ-041 Counter wrap: perform 256 commits -> commit_cnt=0 and commit_done counted 256 times.
